mips_exec_mem_pc: RTL and testbench

// - Single-cycle MIPS execute/memory/fetch-address slice: 32-bit ALU with zero flag,

---
 rtl/mips_pkg.sv | 14 +
 rtl/mips_exec_mem_pc_if.sv | 28 ++
 rtl/alu_core.sv | 27 ++
 rtl/mips_exec_mem_pc.sv | 66 ++++++
 tb/tb_mips_exec_mem_pc.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS execute/memory/pc slice: word width and ALU operation codes.
package mips_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned ALU_CTRL_W = 4;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_CTRL_W-1:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/mips_exec_mem_pc_if.sv
// Operand, memory and branch bus between the decode stage and the execute/memory/pc slice.
interface mips_exec_mem_pc_if;
    import mips_pkg::*;

    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic [XLEN-1:0]       alu_a;
    logic [XLEN-1:0]       alu_b;
    logic [XLEN-1:0]       alu_result;
    logic                  alu_zero;
    logic                  mem_write;
    logic                  mem_read;
    logic [XLEN-1:0]       mem_wdata;
    logic [XLEN-1:0]       mem_rdata;
    logic                  branch;
    logic [XLEN-1:0]       branch_offset;
    logic [XLEN-1:0]       pc;

    modport master (
        output alu_ctrl, alu_a, alu_b, mem_write, mem_read, mem_wdata, branch, branch_offset,
        input  alu_result, alu_zero, mem_rdata, pc
    );

    modport slave (
        input  alu_ctrl, alu_a, alu_b, mem_write, mem_read, mem_wdata, branch, branch_offset,
        output alu_result, alu_zero, mem_rdata, pc
    );

endinterface

// File: rtl/alu_core.sv
// Combinational 32-bit ALU; unknown operation codes produce zero.
module alu_core
    import mips_pkg::*;
(
    input  logic [ALU_CTRL_W-1:0] ctrl_i,
    input  logic [XLEN-1:0]       a_i,
    input  logic [XLEN-1:0]       b_i,
    output logic [XLEN-1:0]       result_c_o,
    output logic                  zero_c_o
);

    always_comb begin
        result_c_o = '0;
        case (ctrl_i)
            ALU_AND: result_c_o = a_i & b_i;
            ALU_OR:  result_c_o = a_i | b_i;
            ALU_ADD: result_c_o = a_i + b_i;
            ALU_SUB: result_c_o = a_i - b_i;
            ALU_SLT: result_c_o = XLEN'($signed(a_i) < $signed(b_i));
            ALU_NOR: result_c_o = ~(a_i | b_i);
            default: result_c_o = '0;
        endcase
    end

    assign zero_c_o = (result_c_o == '0);

endmodule

// File: rtl/mips_exec_mem_pc.sv
// Single-cycle execute/memory/fetch-address slice: ALU, word-addressed data memory and
// branch-capable program counter. Only pc is registered.
module mips_exec_mem_pc
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 256
) (
    input logic                clk,
    input logic                rst_n,
    mips_exec_mem_pc_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);

    logic [XLEN-1:0]  alu_result;
    logic             alu_zero;
    logic [IDX_W-1:0] mem_idx;
    logic [XLEN-1:0]  mem_q [MEM_WORDS];
    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_d;
    logic             unused_addr_bits;

    alu_core u_alu (
        .ctrl_i     (bus.alu_ctrl),
        .a_i        (bus.alu_a),
        .b_i        (bus.alu_b),
        .result_c_o (alu_result),
        .zero_c_o   (alu_zero)
    );

    assign bus.alu_result = alu_result;
    assign bus.alu_zero   = alu_zero;

    // Byte address to word index; byte offset and bits above the depth wrap away.
    assign mem_idx          = alu_result[IDX_W+1:2];
    assign unused_addr_bits = ^{alu_result[XLEN-1:IDX_W+2], alu_result[1:0]};

    // Contents are deliberately not reset; stores are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && bus.mem_write) begin
            mem_q[mem_idx] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata = bus.mem_read ? mem_q[mem_idx] : '0;

    // beq: offset is a word count, taken only when the ALU compare yields zero.
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (bus.branch && alu_zero) begin
            pc_d = pc_q + 32'd4 + (bus.branch_offset << 2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.pc = pc_q;

endmodule

// File: tb/tb_mips_exec_mem_pc.sv
// Directed and randomized checks of the execute/memory/pc slice against a behavioural model.
module tb_mips_exec_mem_pc;

    logic clk = 1'b0;
    logic rst_n;

    mips_exec_mem_pc_if bus ();

    mips_exec_mem_pc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_mem [256];
    bit          m_vld [256];

    function automatic logic [31:0] ref_alu(input logic [3:0] code, input logic [31:0] a,
                                            input logic [31:0] b);
        case (code)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12:   return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    function automatic int unsigned word_of(input logic [31:0] byte_addr);
        return (byte_addr / 4) % 256;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        bus.alu_ctrl = code;
        bus.alu_a    = a;
        bus.alu_b    = b;
    endtask

    task automatic check_comb(input string tag);
        logic [31:0] r;
        int unsigned w;
        r = ref_alu(bus.alu_ctrl, bus.alu_a, bus.alu_b);
        w = word_of(r);
        chk({tag, "_result"}, bus.alu_result, r);
        chk({tag, "_zero"}, 32'(bus.alu_zero), (r == 32'd0) ? 32'd1 : 32'd0);
        if (!bus.mem_read) chk({tag, "_rdata_off"}, bus.mem_rdata, 32'd0);
        else if (m_vld[w]) chk({tag, "_rdata"}, bus.mem_rdata, m_mem[w]);
    endtask

    // One rising edge: model the architectural effect of the current inputs, then compare pc.
    task automatic step(input string tag);
        logic [31:0] r;
        logic [31:0] nxt_pc;
        bit          do_wr;
        int unsigned w;
        r      = ref_alu(bus.alu_ctrl, bus.alu_a, bus.alu_b);
        w      = word_of(r);
        do_wr  = rst_n && bus.mem_write;
        nxt_pc = 32'd0;
        if (rst_n) begin
            nxt_pc = m_pc + 32'd4;
            if (bus.branch && r == 32'd0) nxt_pc = nxt_pc + bus.branch_offset * 32'd4;
        end
        @(posedge clk);
        #1;
        if (do_wr) begin
            m_mem[w] = bus.mem_wdata;
            m_vld[w] = 1'b1;
        end
        m_pc = nxt_pc;
        chk({tag, "_pc"}, bus.pc, m_pc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] codes [8];
        logic [15:0] off16;
        codes = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd3, 4'd15};
        for (int i = 0; i < 256; i++) m_vld[i] = 1'b0;

        rst_n             = 1'b0;
        m_pc              = 32'd0;
        bus.mem_write     = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_wdata     = 32'd0;
        bus.branch        = 1'b0;
        bus.branch_offset = 32'd0;
        drive(4'd0, 32'd0, 32'd0);
        #2;
        chk("reset_pc", bus.pc, 32'd0);
        chk("reset_rdata_off", bus.mem_rdata, 32'd0);

        // ALU directed values
        drive(4'b0010, 32'd7, 32'd5); #1; chk("add", bus.alu_result, 32'd12);
        drive(4'b0110, 32'd7, 32'd5); #1; chk("sub", bus.alu_result, 32'd2);
        chk("sub_zero", 32'(bus.alu_zero), 32'd0);
        drive(4'b0000, 32'd7, 32'd5); #1; chk("and", bus.alu_result, 32'd5);
        drive(4'b0001, 32'd7, 32'd5); #1; chk("or", bus.alu_result, 32'd7);
        drive(4'b1100, 32'd7, 32'd5); #1; chk("nor", bus.alu_result, 32'hFFFF_FFF8);
        drive(4'b0110, 32'd5, 32'd5); #1; chk("sub_eq", bus.alu_result, 32'd0);
        chk("sub_eq_zero", 32'(bus.alu_zero), 32'd1);
        drive(4'b0111, 32'hFFFF_FFFF, 32'd1); #1; chk("slt_neg", bus.alu_result, 32'd1);
        drive(4'b0111, 32'd1, 32'hFFFF_FFFF); #1; chk("slt_pos", bus.alu_result, 32'd0);
        drive(4'b1111, 32'd7, 32'd5); #1; chk("bad_code", bus.alu_result, 32'd0);
        chk("bad_code_zero", 32'(bus.alu_zero), 32'd1);

        // Memory store/load, address aliasing and read-during-write ordering
        @(posedge clk); #2;
        rst_n = 1'b1;
        drive(4'b0010, 32'd8, 32'd0);
        bus.mem_wdata = 32'hDEAD_BEEF;
        bus.mem_write = 1'b1;
        #1; chk("pre_store_rdata_off", bus.mem_rdata, 32'd0);
        step("store");
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b1;
        #1; chk("load8", bus.mem_rdata, 32'hDEAD_BEEF);
        drive(4'b0010, 32'd9, 32'd0); #1; chk("load9", bus.mem_rdata, 32'hDEAD_BEEF);
        drive(4'b0010, 32'd8 + 32'd1024, 32'd0); #1; chk("load_wrap", bus.mem_rdata, 32'hDEAD_BEEF);
        bus.mem_read = 1'b0; #1; chk("load_off", bus.mem_rdata, 32'd0);
        drive(4'b0010, 32'd8, 32'd0);
        bus.mem_read  = 1'b1;
        bus.mem_write = 1'b1;
        bus.mem_wdata = 32'hCAFE_F00D;
        #1; chk("rdw_old", bus.mem_rdata, 32'hDEAD_BEEF);
        step("rdw");
        bus.mem_write = 1'b0;
        #1; chk("rdw_new", bus.mem_rdata, 32'hCAFE_F00D);

        rst_n = 1'b0;
        m_pc  = 32'd0;
        #1; chk("reassert_pc", bus.pc, 32'd0);

        // PC sequencing and branches from a fresh release
        bus.mem_read = 1'b0;
        bus.branch   = 1'b0;
        drive(4'b0000, 32'd0, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        step("seq1"); chk("seq1_const", bus.pc, 32'd4);
        step("seq2"); chk("seq2_const", bus.pc, 32'd8);
        step("seq3"); chk("seq3_const", bus.pc, 32'd12);
        bus.branch = 1'b1;
        drive(4'b0110, 32'd5, 32'd5);
        bus.branch_offset = 32'hFFFF_FFFE;
        step("br_back"); chk("br_back_const", bus.pc, 32'd8);
        bus.branch = 1'b0;
        step("seq4"); chk("seq4_const", bus.pc, 32'd12);
        bus.branch = 1'b1;
        bus.branch_offset = 32'd3;
        step("br_fwd"); chk("br_fwd_const", bus.pc, 32'd28);

        // Reset mid-run with a store attempted while held
        #1;
        rst_n = 1'b0;
        m_pc  = 32'd0;
        #1; chk("midrst_pc", bus.pc, 32'd0);
        bus.branch    = 1'b0;
        bus.mem_write = 1'b1;
        bus.mem_wdata = 32'h1234_5678;
        drive(4'b0010, 32'd8, 32'd0);
        step("midrst_e1");
        step("midrst_e2"); chk("midrst_hold", bus.pc, 32'd0);
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b1;
        #1; chk("midrst_mem", bus.mem_rdata, 32'hCAFE_F00D);
        rst_n = 1'b1;
        bus.mem_read = 1'b0;

        bus.branch = 1'b1;
        drive(4'b0110, 32'd5, 32'd4);
        bus.branch_offset = 32'd3;
        step("br_not_taken"); chk("br_not_taken_const", bus.pc, 32'd4);
        drive(4'b0110, 32'd5, 32'd5);
        bus.branch_offset = 32'hFFFF_FFFF;
        step("br_self"); chk("br_self_const", bus.pc, 32'd4);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            logic [3:0]  code;
            logic [31:0] a;
            logic [31:0] b;
            code = codes[$urandom_range(0, 7)];
            a    = $urandom;
            b    = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                code = 4'd2;
                a    = 32'($urandom_range(0, 2047));
                b    = 32'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 3) == 0) begin
                code = 4'd6;
                b    = a;
            end
            drive(code, a, b);
            bus.mem_write     = 1'($urandom_range(0, 1));
            bus.mem_read      = 1'($urandom_range(0, 1));
            bus.mem_wdata     = $urandom;
            bus.branch        = 1'($urandom_range(0, 1));
            off16             = 16'($urandom);
            bus.branch_offset = {{16{off16[15]}}, off16};
            #1;
            check_comb("rnd");
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
